// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM frame constants and capture FSM encodings
package pwm_pkg;

  localparam int PWM_PERIOD      = 255;
  localparam int DEFAULT_TIMEOUT = 4 * PWM_PERIOD;

  localparam logic [1:0] ACQ  = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  typedef enum logic [1:0] {
    ST_ACQ  = ACQ,
    ST_HIGH = HIGH,
    ST_LOW  = LOW
  } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - 2-FF synchronizer plus delay stage with edge detect
module pwm_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // All stages share one reset value so a high input at release is not a rise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_dly  <= RESET_VAL;
    end else begin
      r_meta <= i_pwm;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_pwm_s = r_sync;
  assign o_rise  = r_sync & ~r_dly;
  assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time / period / level capture with stuck detection
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int PERIOD  = PWM_PERIOD,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_pwm_in,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_high_cycles,
  output logic [WIDTH-1:0] o_period_cycles,
  output logic [7:0]       o_level,
  output logic             o_period_ok,
  output logic             o_stuck,
  output logic             o_stuck_val
);

  localparam logic [WIDTH-1:0] CNT_TIMEOUT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_PERIOD  = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] CNT_SAT     = WIDTH'(255);

  logic             w_pwm_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic             w_publish;
  logic             w_latch_high;
  logic             w_clear_high;
  logic [7:0]       w_level_sat;
  cap_state_t       r_state;
  cap_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_high_lat;

  pwm_sync_edge #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_pwm   (i_pwm_in),
    .o_pwm_s (w_pwm_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // A rise landing on the timeout cycle wins and is measured normally.
  assign w_timeout   = (r_cnt == CNT_TIMEOUT) && !w_rise;
  assign w_level_sat = (r_high_lat > CNT_SAT) ? 8'hFF : r_high_lat[7:0];

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_ACQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_publish    = 1'b0;
    w_latch_high = 1'b0;
    w_clear_high = 1'b0;
    if (w_rise) begin
      w_state_nxt  = ST_HIGH;
      w_publish    = (r_state == ST_LOW);
      w_clear_high = (r_state == ST_ACQ);
    end else if (w_timeout) begin
      w_state_nxt = ST_ACQ;
    end else if (w_fall && r_state == ST_HIGH) begin
      w_latch_high = 1'b1;
      w_state_nxt  = ST_LOW;
    end
  end

  // cnt holds the number of cycles since the last rise; timeout restarts it.
  always_ff @(posedge clk) begin
    if (!rstn)          r_cnt <= '0;
    else if (w_rise)    r_cnt <= WIDTH'(1);
    else if (w_timeout) r_cnt <= '0;
    else                r_cnt <= r_cnt + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn)             r_high_lat <= '0;
    else if (w_clear_high) r_high_lat <= '0;
    else if (w_latch_high) r_high_lat <= r_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_valid         <= 1'b0;
      o_high_cycles   <= '0;
      o_period_cycles <= '0;
      o_level         <= 8'd0;
      o_period_ok     <= 1'b0;
      o_stuck         <= 1'b0;
      o_stuck_val     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (w_publish) begin
        o_valid         <= 1'b1;
        o_high_cycles   <= r_high_lat;
        o_period_cycles <= r_cnt;
        o_level         <= w_level_sat;
        o_period_ok     <= (r_cnt == CNT_PERIOD);
        o_stuck         <= 1'b0;
      end else if (w_timeout) begin
        o_valid         <= 1'b1;
        o_high_cycles   <= '0;
        o_period_cycles <= '0;
        o_level         <= {8{w_pwm_s}};
        o_period_ok     <= 1'b0;
        o_stuck         <= 1'b1;
        o_stuck_val     <= w_pwm_s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  logic       clk;
  logic       rstn;
  logic       i_pwm_in;
  logic       o_valid;
  logic [9:0] o_high_cycles;
  logic [9:0] o_period_cycles;
  logic [7:0] o_level;
  logic       o_period_ok;
  logic       o_stuck;
  logic       o_stuck_val;

  int n_checks;
  int n_errors;

  // driver modes: 0 idle, 1 generator, 2 custom high/low, 3 async clk/2
  int mode;
  int gen_level;
  int hi_len;
  int lo_len;

  pwm_capture #(.WIDTH(10), .PERIOD(255), .TIMEOUT(1020)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_pwm_in        (i_pwm_in),
    .o_valid         (o_valid),
    .o_high_cycles   (o_high_cycles),
    .o_period_cycles (o_period_cycles),
    .o_level         (o_level),
    .o_period_ok     (o_period_ok),
    .o_stuck         (o_stuck),
    .o_stuck_val     (o_stuck_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int gcnt;
    int ccnt;
    int last_mode;
    gcnt      = 0;
    ccnt      = 0;
    last_mode = 0;
    i_pwm_in  = 1'b0;
    forever begin
      if (mode == 3) begin
        #2 i_pwm_in = ~i_pwm_in;
        #8;
      end else begin
        @(negedge clk);
        if (mode != last_mode) begin
          gcnt = 0;
          ccnt = 0;
        end
        last_mode = mode;
        if (mode == 1) begin
          i_pwm_in = (gcnt < gen_level);
          gcnt     = (gcnt == 254) ? 0 : gcnt + 1;
        end else if (mode == 2) begin
          i_pwm_in = (ccnt < hi_len);
          ccnt     = (ccnt == hi_len + lo_len - 1) ? 0 : ccnt + 1;
        end else begin
          i_pwm_in = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int elapsed);
    bit seen;
    seen    = 1'b0;
    elapsed = 0;
    while (!seen && elapsed < budget) begin
      @(posedge clk);
      #1;
      elapsed++;
      if (o_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  task automatic do_reset();
    @(negedge clk) rstn = 1'b0;
    @(negedge clk);
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic check_meas(input string tag, input int hi, input int per, input int lvl,
                            input bit ok);
    check({tag, "_high"},   o_high_cycles,   hi);
    check({tag, "_period"}, o_period_cycles, per);
    check({tag, "_level"},  o_level,         lvl);
    check({tag, "_pok"},    o_period_ok,     ok);
    check({tag, "_stuck"},  o_stuck,         0);
  endtask

  initial begin
    int  el;
    int  gap;
    int  tries;
    n_checks  = 0;
    n_errors  = 0;
    mode      = 0;
    gen_level = 0;
    hi_len    = 1;
    lo_len    = 1;
    rstn      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  o_valid,         0);
    check("rst_high",   o_high_cycles,   0);
    check("rst_period", o_period_cycles, 0);
    check("rst_level",  o_level,         0);
    check("rst_pok",    o_period_ok,     0);
    check("rst_stuck",  o_stuck,         0);
    check("rst_sval",   o_stuck_val,     0);

    // generator loopback at level 64
    mode = 1; gen_level = 64;
    do_reset();
    wait_valid("lb_v1", 2000, el);
    wait_valid("lb_v2", 400, el);
    check_meas("lb", 64, 255, 64, 1);
    wait_valid("lb_v3", 400, el);
    check("lb_interval", el, 255);
    @(posedge clk); #1;
    check("lb_pulse_width", o_valid, 0);

    // level change mid-frame
    repeat (30) @(posedge clk);
    gen_level = 200;
    wait_valid("lc_v1", 400, el);
    wait_valid("lc_v2", 400, el);
    check_meas("lc", 200, 255, 200, 1);

    // stuck low then stuck high
    for (int s = 0; s < 2; s++) begin
      gen_level = (s == 0) ? 0 : 255;
      do_reset();
      wait_valid("stk_v1", 1100, el);
      check("stk_first_time", (el >= 1020 && el <= 1022), 1);
      check("stk_flag",   o_stuck,         1);
      check("stk_val",    o_stuck_val,     s);
      check("stk_level",  o_level,         (s == 0) ? 0 : 255);
      check("stk_high",   o_high_cycles,   0);
      check("stk_period", o_period_cycles, 0);
      check("stk_pok",    o_period_ok,     0);
      wait_valid("stk_v2", 1100, gap);
      check("stk_repeat_gap", (gap >= 1020 && gap <= 1021), 1);
      check("stk_repeat_flag", o_stuck, 1);
    end

    // non-nominal 300 high / 200 low
    mode = 2; hi_len = 300; lo_len = 200;
    do_reset();
    wait_valid("nn_v1", 1200, el);
    wait_valid("nn_v2", 600, el);
    check_meas("nn", 300, 500, 255, 0);

    // one-cycle reset in the middle of a high phase
    repeat (100) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    check("mr_valid",  o_valid,         0);
    check("mr_high",   o_high_cycles,   0);
    check("mr_period", o_period_cycles, 0);
    check("mr_level",  o_level,         0);
    check("mr_stuck",  o_stuck,         0);
    wait_valid("mr_v1", 1100, el);
    check("mr_first_time", (el >= 880 && el <= 920), 1);
    check_meas("mr", 300, 500, 255, 0);

    // rise exactly at cnt == TIMEOUT: 100 high / 920 low
    hi_len = 100; lo_len = 920;
    do_reset();
    tries = 0;
    wait_valid("bd_v", 2200, el);
    while (o_stuck && tries < 3) begin
      wait_valid("bd_vn", 2200, el);
      tries++;
    end
    wait_valid("bd_v2", 1100, el);
    check("bd_interval", el, 1020);
    check_meas("bd", 100, 1020, 100, 0);

    // asynchronous clk/2 input from a skewed clock
    mode = 3;
    do_reset();
    wait_valid("as_v1", 50, el);
    wait_valid("as_v2", 10, el);
    check("as_interval", el, 2);
    check_meas("as", 1, 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
